// File: rtl/spi_master_duplex_if.sv
// Bundle of the SPI master's control handshake and pin signals.
// The master modport is the DUT's view; slave is the controller/pin side.
interface spi_master_duplex_if #(
   parameter int WIDTH  = 8,
   parameter int NUM_CS = 2,
   parameter int CS_W   = 1
);
   logic              start;
   logic [WIDTH-1:0]  tx_data;
   logic [CS_W-1:0]   cs_sel;
   logic              cpol;
   logic              cpha;
   logic              busy;
   logic              done;
   logic              cs_err;
   logic [WIDTH-1:0]  rx_data;
   logic              spi_clk;
   logic              mosi;
   logic              miso;
   logic [NUM_CS-1:0] chip_select;

   modport master (
      input  start, tx_data, cs_sel, cpol, cpha, miso,
      output busy, done, cs_err, rx_data, spi_clk, mosi, chip_select
   );

   modport slave (
      output start, tx_data, cs_sel, cpol, cpha, miso,
      input  busy, done, cs_err, rx_data, spi_clk, mosi, chip_select
   );
endinterface

// File: rtl/spi_master_duplex.sv
// Full-duplex SPI master: runtime CPOL/CPHA, CLK_DIV-cycle SCLK half-periods,
// one-hot active-low chip selects, MSB-first shift out and simultaneous shift in.
module spi_master_duplex #(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 4,
   parameter int NUM_CS  = 2,
   parameter int CS_W    = 1
) (
   input  logic clock,
   input  logic reset,
   spi_master_duplex_if.master bus
);

   localparam int HC_W = $clog2(CLK_DIV);
   localparam int TC_W = $clog2(2*WIDTH+1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_XFER  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [HC_W-1:0]   hc_q, hc_d, hc_nxt;
   logic [TC_W-1:0]   tc_q, tc_d;
   logic [WIDTH-1:0]  txs_q, txs_d;
   logic [WIDTH-1:0]  rxs_q, rxs_d;
   logic [WIDTH-1:0]  rx_q, rx_d;
   logic [NUM_CS-1:0] cs_q, cs_d, cs_sel_n;
   logic              mosi_q, mosi_d;
   logic              spi_clk_q, spi_clk_d;
   logic              cpol_q, cpol_d;
   logic              cpha_q, cpha_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              cs_err_q, cs_err_d;
   logic              hc_wrap, toggle, leading, cs_bad;

   // When every encodable index names a real chip select there is nothing to reject.
   if ((1 << CS_W) <= NUM_CS) begin : g_cs_all
      assign cs_bad = 1'b0;
   end else begin : g_cs_chk
      assign cs_bad = (bus.cs_sel >= CS_W'(NUM_CS));
   end

   always_comb begin
      cs_sel_n = '1;
      for (int i = 0; i < NUM_CS; i++)
         if (bus.cs_sel == CS_W'(i)) cs_sel_n[i] = 1'b0;
   end

   always_comb begin
      state_d   = state_q;
      hc_d      = hc_q;
      tc_d      = tc_q;
      txs_d     = txs_q;
      rxs_d     = rxs_q;
      rx_d      = rx_q;
      cs_d      = cs_q;
      mosi_d    = mosi_q;
      spi_clk_d = spi_clk_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cs_err_d  = 1'b0;
      toggle    = 1'b0;
      leading   = 1'b0;
      hc_wrap   = (hc_q == HC_W'(CLK_DIV-1));
      hc_nxt    = hc_wrap ? '0 : hc_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            spi_clk_d = cpol_q;
            if (bus.start) begin
               if (cs_bad) begin
                  cs_err_d = 1'b1;
               end else begin
                  state_d   = S_SETUP;
                  hc_d      = '0;
                  tc_d      = '0;
                  txs_d     = bus.tx_data;
                  rxs_d     = '0;
                  cpol_d    = bus.cpol;
                  cpha_d    = bus.cpha;
                  spi_clk_d = bus.cpol;
                  busy_d    = 1'b1;
                  cs_d      = cs_sel_n;
                  mosi_d    = bus.cpha ? 1'b0 : bus.tx_data[WIDTH-1];
               end
            end
         end
         S_SETUP: begin
            hc_d = hc_nxt;
            if (hc_wrap) begin
               state_d = S_XFER;
               toggle  = 1'b1;
            end
         end
         S_XFER: begin
            hc_d = hc_nxt;
            if (hc_wrap) begin
               if (tc_q == TC_W'(2*WIDTH)) state_d = S_HOLD;
               else                        toggle  = 1'b1;
            end
         end
         S_HOLD: begin
            hc_d = hc_nxt;
            if (hc_wrap) begin
               state_d = S_DONE;
               cs_d    = '1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               rx_d    = rxs_q;
               mosi_d  = 1'b0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // tc_q counts toggles already made, so an even tc_q means this toggle is odd (leading).
      if (toggle) begin
         spi_clk_d = ~spi_clk_q;
         tc_d      = tc_q + 1'b1;
         leading   = ~tc_q[0];
         if (cpha_q == 1'b0) begin
            if (leading)
               rxs_d = {rxs_q[WIDTH-2:0], bus.miso};
            else if (tc_q != TC_W'(2*WIDTH-1)) begin
               mosi_d = txs_q[WIDTH-2];
               txs_d  = {txs_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            if (leading) begin
               mosi_d = txs_q[WIDTH-1];
               txs_d  = {txs_q[WIDTH-2:0], 1'b0};
            end else
               rxs_d = {rxs_q[WIDTH-2:0], bus.miso};
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         hc_q      <= '0;
         tc_q      <= '0;
         txs_q     <= '0;
         rxs_q     <= '0;
         rx_q      <= '0;
         cs_q      <= '1;
         mosi_q    <= 1'b0;
         spi_clk_q <= 1'b0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cs_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         hc_q      <= hc_d;
         tc_q      <= tc_d;
         txs_q     <= txs_d;
         rxs_q     <= rxs_d;
         rx_q      <= rx_d;
         cs_q      <= cs_d;
         mosi_q    <= mosi_d;
         spi_clk_q <= spi_clk_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cs_err_q  <= cs_err_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.cs_err      = cs_err_q;
   assign bus.rx_data     = rx_q;
   assign bus.spi_clk     = spi_clk_q;
   assign bus.mosi        = mosi_q;
   assign bus.chip_select = cs_q;

endmodule

// File: tb/tb_spi_master_duplex.sv
// Bench for spi_master_duplex: table vectors, corner sequences and random
// transfers against a bit-level SPI slave model and word-level expectations.
module tb_spi_master_duplex;

   localparam int W   = 8;
   localparam int D   = 4;
   localparam int LAT = (2*W+2)*D+1;
   localparam int TMO = 400;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   spi_master_duplex_if #(.WIDTH(W), .NUM_CS(2), .CS_W(1)) bus ();
   spi_master_duplex_if #(.WIDTH(W), .NUM_CS(1), .CS_W(1)) bus1 ();

   spi_master_duplex #(.WIDTH(W), .CLK_DIV(D), .NUM_CS(2), .CS_W(1)) u_dut (
      .clock(clock), .reset(reset), .bus(bus));
   spi_master_duplex #(.WIDTH(W), .CLK_DIV(D), .NUM_CS(1), .CS_W(1)) u_dut1 (
      .clock(clock), .reset(reset), .bus(bus1));

   int checks   = 0;
   int failures = 0;

   // Slave model: counts SCLK edges while selected, captures and drives per CPHA.
   logic         lpbk = 1'b1;
   logic         cur_cpha = 1'b0;
   logic [W-1:0] slv_word = '0;
   logic [W-1:0] slv_cap = '0;
   logic         slv_bit = 1'b0;
   int           slv_idx = 0;
   int           sclk_cnt = 0;
   logic         prev_act = 1'b0;
   logic         prev_sclk_s = 1'b0;

   assign bus.miso  = lpbk ? bus.mosi : slv_bit;
   assign bus1.miso = bus1.mosi;

   always @(negedge clock) begin
      logic act;
      act = ~&bus.chip_select;
      if (act && !prev_act) begin
         sclk_cnt = 0;
         slv_cap  = '0;
         slv_idx  = W-1;
         slv_bit  = cur_cpha ? 1'b0 : slv_word[W-1];
      end else if (act && bus.spi_clk != prev_sclk_s) begin
         sclk_cnt++;
         if ((sclk_cnt % 2 == 1) != cur_cpha)
            slv_cap = {slv_cap[W-2:0], bus.mosi};
         else if (cur_cpha) begin
            slv_bit = slv_word[slv_idx];
            slv_idx--;
         end else if (slv_idx > 0) begin
            slv_idx--;
            slv_bit = slv_word[slv_idx];
         end
      end
      prev_act    = act;
      prev_sclk_s = bus.spi_clk;
   end

   typedef struct {
      logic [W-1:0] tx;
      logic         sel;
      logic         cpol;
      logic         cpha;
      logic         lpbk;
      logic [W-1:0] sw;
      logic [W-1:0] exp_rx;
      logic [1:0]   exp_cs;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Starts a transfer from an idle negedge and follows it to the cycle after done.
   task automatic xfer(input vec_t v, input int poke, input bit hold);
      int cyc, done_cyc, rise, extra;
      bit cs_bad, rx_chg, busy_bad, prev_sclk;
      logic [W-1:0] rx_prev;
      bus.tx_data = v.tx;   bus.cs_sel = v.sel;
      bus.cpol    = v.cpol; bus.cpha   = v.cpha;
      bus.start   = 1'b1;
      lpbk = v.lpbk; slv_word = v.sw; cur_cpha = v.cpha;
      rx_prev = bus.rx_data;
      cyc = 0; done_cyc = 0; rise = 0; extra = 0;
      cs_bad = 0; rx_chg = 0; busy_bad = 0; prev_sclk = v.cpol;
      @(posedge clock);
      while (done_cyc == 0 && cyc < TMO) begin
         @(negedge clock);
         cyc++;
         if (cyc == 1) chk("sclk_idle_lvl", {31'd0, bus.spi_clk}, {31'd0, v.cpol});
         if (cyc == 1 && !hold) bus.start = 1'b0;
         if (poke != 0 && cyc == poke) begin
            bus.start = 1'b1; bus.tx_data = 8'h11;
            bus.cs_sel = ~v.sel; bus.cpol = ~v.cpol; bus.cpha = ~v.cpha;
         end
         if (poke != 0 && cyc == poke+1) bus.start = 1'b0;
         if (bus.done) done_cyc = cyc;
         else begin
            if (bus.chip_select !== v.exp_cs) cs_bad = 1;
            if (bus.rx_data !== rx_prev) rx_chg = 1;
            if (bus.busy !== 1'b1) busy_bad = 1;
            if (bus.spi_clk && !prev_sclk) rise++;
            prev_sclk = bus.spi_clk;
         end
      end
      chk("done_latency", done_cyc, LAT);
      chk("rx_data", {24'd0, bus.rx_data}, {24'd0, v.exp_rx});
      chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
      chk("cs_at_done", {30'd0, bus.chip_select}, 32'h3);
      chk("sclk_end_lvl", {31'd0, bus.spi_clk}, {31'd0, v.cpol});
      chk("cs_during", {31'd0, cs_bad}, 32'd0);
      chk("busy_during", {31'd0, busy_bad}, 32'd0);
      chk("rx_stable", {31'd0, rx_chg}, 32'd0);
      chk("sclk_rises", rise, W);
      if (!v.lpbk) chk("slave_capture", {24'd0, slv_cap}, {24'd0, v.tx});
      @(negedge clock);
      chk("done_pulse_w", {31'd0, bus.done}, 32'd0);
      chk("busy_after", {31'd0, bus.busy}, 32'd0);
      if (poke != 0) begin
         repeat (20) begin
            @(negedge clock);
            if (bus.done || bus.busy) extra++;
         end
         chk("no_queued_xfer", extra, 0);
      end
   endtask

   vec_t tbl [5];
   vec_t rv;

   initial begin
      bus.start = 0; bus.tx_data = '0; bus.cs_sel = '0; bus.cpol = 0; bus.cpha = 0;
      bus1.start = 0; bus1.tx_data = '0; bus1.cs_sel = '0; bus1.cpol = 0; bus1.cpha = 0;

      tbl[0] = '{tx:8'hA5, sel:1'b0, cpol:1'b0, cpha:1'b0, lpbk:1'b1, sw:8'h00, exp_rx:8'hA5, exp_cs:2'b10};
      tbl[1] = '{tx:8'hF0, sel:1'b1, cpol:1'b1, cpha:1'b1, lpbk:1'b0, sw:8'h3C, exp_rx:8'h3C, exp_cs:2'b01};
      tbl[2] = '{tx:8'h96, sel:1'b1, cpol:1'b0, cpha:1'b1, lpbk:1'b0, sw:8'hE1, exp_rx:8'hE1, exp_cs:2'b01};
      tbl[3] = '{tx:8'h4B, sel:1'b0, cpol:1'b1, cpha:1'b0, lpbk:1'b0, sw:8'h81, exp_rx:8'h81, exp_cs:2'b10};
      tbl[4] = '{tx:8'h7E, sel:1'b0, cpol:1'b1, cpha:1'b1, lpbk:1'b1, sw:8'h00, exp_rx:8'h7E, exp_cs:2'b10};

      repeat (3) @(negedge clock);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_cs_err", {31'd0, bus.cs_err}, 32'd0);
      chk("rst_rx", {24'd0, bus.rx_data}, 32'd0);
      chk("rst_mosi", {31'd0, bus.mosi}, 32'd0);
      chk("rst_sclk", {31'd0, bus.spi_clk}, 32'd0);
      chk("rst_cs", {30'd0, bus.chip_select}, 32'h3);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 5; i++) xfer(tbl[i], 0, 1'b0);

      // Mid-transfer start with new data/mode must be ignored.
      rv = '{tx:8'hC3, sel:1'b0, cpol:1'b0, cpha:1'b0, lpbk:1'b1, sw:8'h00, exp_rx:8'hC3, exp_cs:2'b10};
      xfer(rv, 20, 1'b0);

      // Rejected chip select on the single-CS build.
      bus1.cs_sel = 1'b1; bus1.start = 1'b1;
      @(negedge clock);
      bus1.start = 1'b0;
      chk("cs_err_pulse", {31'd0, bus1.cs_err}, 32'd1);
      chk("cs_err_cs", {31'd0, bus1.chip_select}, 32'd1);
      chk("cs_err_busy", {31'd0, bus1.busy}, 32'd0);
      @(negedge clock);
      chk("cs_err_1cyc", {31'd0, bus1.cs_err}, 32'd0);
      chk("cs_err_idle", {31'd0, bus1.busy}, 32'd0);

      // Reset 30 cycles into a transfer of 0x5A.
      bus.tx_data = 8'h5A; bus.cs_sel = 1'b1; bus.cpol = 1'b1; bus.cpha = 1'b0;
      lpbk = 1'b1; bus.start = 1'b1;
      @(posedge clock);
      repeat (30) @(negedge clock);
      bus.start = 1'b0;
      chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk("arst_cs", {30'd0, bus.chip_select}, 32'h3);
      chk("arst_sclk", {31'd0, bus.spi_clk}, 32'd0);
      chk("arst_busy", {31'd0, bus.busy}, 32'd0);
      chk("arst_rx", {24'd0, bus.rx_data}, 32'd0);
      begin
         int dn = 0;
         repeat (4) begin @(negedge clock); if (bus.done) dn++; end
         reset = 1'b0;
         repeat (60) begin @(negedge clock); if (bus.done) dn++; end
         chk("arst_no_done", dn, 0);
      end
      rv = '{tx:8'h5A, sel:1'b1, cpol:1'b0, cpha:1'b0, lpbk:1'b1, sw:8'h00, exp_rx:8'h5A, exp_cs:2'b01};
      xfer(rv, 0, 1'b0);

      // Back-to-back with start held high across done.
      rv = '{tx:8'h01, sel:1'b0, cpol:1'b0, cpha:1'b0, lpbk:1'b1, sw:8'h00, exp_rx:8'h01, exp_cs:2'b10};
      xfer(rv, 0, 1'b1);
      rv = '{tx:8'h80, sel:1'b0, cpol:1'b0, cpha:1'b0, lpbk:1'b1, sw:8'h00, exp_rx:8'h80, exp_cs:2'b10};
      xfer(rv, 0, 1'b0);

      // Random transfers; expectations follow from the SPI rules alone.
      for (int i = 0; i < 10; i++) begin
         rv.tx     = W'($urandom);
         rv.sw     = W'($urandom);
         rv.sel    = 1'($urandom_range(1));
         rv.cpol   = 1'($urandom_range(1));
         rv.cpha   = 1'($urandom_range(1));
         rv.lpbk   = 1'($urandom_range(1));
         rv.exp_rx = rv.lpbk ? rv.tx : rv.sw;
         rv.exp_cs = ~(2'b01 << rv.sel);
         repeat ($urandom_range(3)) @(negedge clock);
         xfer(rv, 0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
